// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates renamed instructions at the tail,
// marks completion from writeback, retires from the head, flushes on mispredict.
module reorder_buffer #(
  parameter int N_ENTRIES = 16,
  parameter int PREG_W    = 6,
  parameter int TAG_W     = $clog2(N_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_rd_used_i,
  input  logic [PREG_W-1:0] alloc_rd_new_p_i,
  input  logic [PREG_W-1:0] alloc_rd_old_p_i,
  input  logic              alloc_is_branch_i,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic              wb_mispredict_i,
  output logic              commit_valid_o,
  output logic [TAG_W-1:0]  commit_tag_o,
  output logic              commit_free_valid_o,
  output logic [PREG_W-1:0] commit_free_preg_o,
  output logic              recover_o,
  output logic [TAG_W:0]    count_o
);

  localparam int PW = TAG_W + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, count;
  logic [N_ENTRIES-1:0] valid_q, valid_d, done_q, done_d;
  logic [N_ENTRIES-1:0] used_q, used_d, br_q, br_d;
  logic [N_ENTRIES-1:0][PREG_W-1:0] old_q, old_d, new_q, new_d;

  logic              cvalid_q, cvalid_d, fvalid_q, fvalid_d;
  logic [TAG_W-1:0]  ctag_q, ctag_d;
  logic [PREG_W-1:0] fpreg_q, fpreg_d;
  logic              recover_q, recover_d;

  logic [TAG_W-1:0] head_idx, tail_idx, mp_off, off_i;
  logic mp_hit, alloc_fire, commit_fire;

  // rd_new is kept per entry for debug visibility; nothing downstream reads it
  logic rd_new_unused;
  assign rd_new_unused = ^new_q;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign count    = tail_q - head_q;
  assign mp_hit   = wb_valid_i && wb_mispredict_i
                 && valid_q[wb_tag_i] && br_q[wb_tag_i];
  assign mp_off   = wb_tag_i - head_idx;

  assign alloc_ready_o = !rst && (count < PW'(N_ENTRIES)) && !mp_hit;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign commit_fire   = valid_q[head_idx] && done_q[head_idx];

  assign alloc_tag_o         = tail_idx;
  assign count_o             = count;
  assign commit_valid_o      = cvalid_q;
  assign commit_tag_o        = ctag_q;
  assign commit_free_valid_o = fvalid_q;
  assign commit_free_preg_o  = fpreg_q;
  assign recover_o           = recover_q;

  // next state: writeback, flush, retire, then allocate
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    used_d  = used_q;
    br_d    = br_q;
    old_d   = old_q;
    new_d   = new_q;
    head_d  = head_q;
    tail_d  = tail_q;
    off_i   = '0;

    if (wb_valid_i && valid_q[wb_tag_i])
      done_d[wb_tag_i] = 1'b1;

    if (mp_hit) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        off_i = TAG_W'(i) - head_idx;
        if (off_i > mp_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d = head_q + {1'b0, mp_off} + PW'(1);
    end

    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d = head_q + PW'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      used_d[tail_idx]  = alloc_rd_used_i;
      br_d[tail_idx]    = alloc_is_branch_i;
      old_d[tail_idx]   = alloc_rd_old_p_i;
      new_d[tail_idx]   = alloc_rd_new_p_i;
      tail_d = tail_q + PW'(1);
    end

    cvalid_d  = commit_fire;
    ctag_d    = commit_fire ? head_idx : '0;
    fvalid_d  = commit_fire && used_q[head_idx]
             && (old_q[head_idx] != '0);
    fpreg_d   = fvalid_d ? old_q[head_idx] : '0;
    recover_d = mp_hit;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      used_q    <= '0;
      br_q      <= '0;
      old_q     <= '0;
      new_q     <= '0;
      cvalid_q  <= 1'b0;
      ctag_q    <= '0;
      fvalid_q  <= 1'b0;
      fpreg_q   <= '0;
      recover_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      used_q    <= used_d;
      br_q      <= br_d;
      old_q     <= old_d;
      new_q     <= new_d;
      cvalid_q  <= cvalid_d;
      ctag_q    <= ctag_d;
      fvalid_q  <= fvalid_d;
      fpreg_q   <= fpreg_d;
      recover_q <= recover_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued in
// program order at allocation and popped as commits appear.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid_i, alloc_ready_o, alloc_rd_used_i, alloc_is_branch_i;
  logic [5:0] alloc_rd_new_p_i, alloc_rd_old_p_i;
  logic [3:0] alloc_tag_o;
  logic       wb_valid_i, wb_mispredict_i;
  logic [3:0] wb_tag_i;
  logic       commit_valid_o, commit_free_valid_o, recover_o;
  logic [3:0] commit_tag_o;
  logic [5:0] commit_free_preg_o;
  logic [4:0] count_o;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rd_used_i(alloc_rd_used_i), .alloc_rd_new_p_i(alloc_rd_new_p_i),
    .alloc_rd_old_p_i(alloc_rd_old_p_i), .alloc_is_branch_i(alloc_is_branch_i),
    .alloc_tag_o(alloc_tag_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_mispredict_i(wb_mispredict_i),
    .commit_valid_o(commit_valid_o), .commit_tag_o(commit_tag_o),
    .commit_free_valid_o(commit_free_valid_o), .commit_free_preg_o(commit_free_preg_o),
    .recover_o(recover_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic       fv;
    logic [5:0] p;
  } exp_t;

  exp_t q[$];
  logic [4:0] mtail;
  int nchk = 0;
  int nerr = 0;
  int ncommit = 0;

  task automatic check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // retirement monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst && commit_valid_o) begin
      ncommit++;
      if (q.size() == 0) begin
        check("unexp_commit", 1, 0);
      end else begin
        e = q.pop_front();
        check("ctag", commit_tag_o, e.tag);
        check("cfree_v", commit_free_valid_o, e.fv);
        if (e.fv) check("cfree_p", commit_free_preg_o, e.p);
      end
    end
    if (!rst && !commit_valid_o && commit_free_valid_o)
      check("stray_free", 1, 0);
  end

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid_i = 1'b0;
    wb_valid_i = 1'b0;
    wb_mispredict_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", alloc_ready_o, 0);
    check("rst_count", count_o, 0);
    check("rst_atag", alloc_tag_o, 0);
    check("rst_cvalid", commit_valid_o, 0);
    check("rst_fvalid", commit_free_valid_o, 0);
    check("rst_recover", recover_o, 0);
    q.delete();
    mtail = '0;
    rst = 1'b0;
    #1;
    check("rst_ready_after", alloc_ready_o, 1);
  endtask

  task automatic do_alloc(input logic used, input logic [5:0] old,
                          input logic br);
    exp_t e;
    alloc_valid_i = 1'b1;
    alloc_rd_used_i = used;
    alloc_rd_old_p_i = old;
    alloc_rd_new_p_i = 6'(old + 6'd20);
    alloc_is_branch_i = br;
    #1;
    check("alloc_tag", alloc_tag_o, mtail[3:0]);
    check("alloc_ready", alloc_ready_o, 1);
    e.tag = mtail[3:0];
    e.fv = used && (old != 0);
    e.p = old;
    q.push_back(e);
    mtail = mtail + 5'd1;
    @(posedge clk);
    #1;
    alloc_valid_i = 1'b0;
  endtask

  task automatic do_wb(input logic [3:0] tag, input logic mp);
    wb_valid_i = 1'b1;
    wb_tag_i = tag;
    wb_mispredict_i = mp;
    #1;
    if (mp) begin
      check("mp_block_ready", alloc_ready_o, 0);
      while (q.size() > 0 && q[$].tag != tag) void'(q.pop_back());
      mtail = {mtail[4], tag} + 5'd1;
    end
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    wb_mispredict_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && count_o == 0) break;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    check("drain_q", q.size(), 0);
    check("drain_count", count_o, 0);
  endtask

  initial begin
    alloc_rd_used_i = 0;
    alloc_rd_old_p_i = 0;
    alloc_rd_new_p_i = 0;
    alloc_is_branch_i = 0;
    wb_tag_i = 0;
    mtail = 0;
    @(negedge clk);

    // in-order completion, preg 0 never freed
    do_reset();
    do_alloc(1, 6'd5, 0);
    do_alloc(1, 6'd6, 0);
    do_alloc(1, 6'd0, 0);
    check("cnt3", count_o, 3);
    do_wb(0, 0);
    do_wb(1, 0);
    do_wb(2, 0);
    drain();

    // out-of-order completion retires in order
    do_reset();
    ncommit = 0;
    do_alloc(1, 6'd7, 0);
    do_alloc(0, 6'd8, 0);
    do_alloc(1, 6'd9, 0);
    do_wb(2, 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_early_commit", ncommit, 0);
    do_wb(0, 0);
    do_wb(1, 0);
    drain();
    check("ooo_ncommit", ncommit, 3);

    // fill, commit one, wrap tail
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(1, 6'(i + 1), 0);
    check("full_ready", alloc_ready_o, 0);
    check("full_count", count_o, 16);
    do_wb(0, 0);
    @(posedge clk);
    #1;
    check("ready_after_commit", alloc_ready_o, 1);
    check("count_after_commit", count_o, 15);
    do_alloc(1, 6'd33, 0);
    check("wrap_count", count_o, 16);
    check("wrap_ready", alloc_ready_o, 0);
    check("wrap_atag", alloc_tag_o, 1);
    for (int i = 1; i < 16; i++) do_wb(4'(i), 0);
    do_wb(0, 0);
    drain();

    // mispredict flushes younger entries
    do_reset();
    for (int i = 0; i < 6; i++) do_alloc(1, 6'(10 + i), (i == 2));
    do_wb(2, 1);
    check("recover_pulse", recover_o, 1);
    check("mp_count", count_o, 3);
    check("mp_atag", alloc_tag_o, 3);
    @(posedge clk);
    #1;
    check("recover_clear", recover_o, 0);
    do_wb(4, 0);
    check("ign_count", count_o, 3);
    do_wb(0, 0);
    do_wb(1, 0);
    drain();

    // mispredict coincident with head commit
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(1, 6'(i + 1), 0);
    for (int i = 0; i < 4; i++) do_wb(4'(i), 0);
    drain();
    for (int i = 4; i < 10; i++) do_alloc(1, 6'(i + 40), (i == 6));
    check("pre_count", count_o, 6);
    do_wb(4, 0);
    do_wb(6, 1);
    check("co_count", count_o, 2);
    check("co_atag", alloc_tag_o, 7);
    check("co_recover", recover_o, 1);
    do_wb(5, 0);
    drain();

    // reset mid-flight drops everything silently
    do_reset();
    for (int i = 0; i < 5; i++) do_alloc(1, 6'(i + 3), 0);
    check("pend_count", count_o, 5);
    do_reset();
    ncommit = 0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_commits", ncommit, 0);
    check("post_rst_count", count_o, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
